// File: rtl/usb_crc_pkg.sv
// Shared types and CRC constants for the USB transmit-side CRC encoder and
// the matching receive-side checker.
package usb_crc_pkg;

  typedef enum logic {
    CRC_5  = 1'b0,
    CRC_16 = 1'b1
  } crc_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PID,
    S_PAYLOAD,
    S_CRC
  } enc_state_t;

  // Polynomials are written without the implicit leading x^n term.
  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam int          CRC5_LEN   = 5;
  localparam int          CRC16_LEN  = 16;

endpackage

// File: rtl/usb_crc_lfsr.sv
// Galois CRC LFSR shared by the USB CRC5/CRC16 encoder and checker; exposes one
// complemented remainder bit selected by index.
module usb_crc_lfsr
  import usb_crc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       init,
  input  logic       shift_en,
  input  logic       data_bit,
  input  crc_mode_t  mode,
  input  logic [3:0] index,
  output logic       rem_bit
);

  logic [15:0] lfsr;
  logic [15:0] poly;
  logic        feedback;

  // CRC5 lives in lfsr[4:0]; the bits above it churn but are never read out.
  assign feedback = data_bit ^ ((mode == CRC_16) ? lfsr[CRC16_LEN-1] : lfsr[CRC5_LEN-1]);
  assign poly     = (mode == CRC_16) ? CRC16_POLY : 16'(CRC5_POLY);
  assign rem_bit  = ~lfsr[index];

  always_ff @(posedge clock) begin
    if (reset || init) begin
      lfsr <= '1;
    end else if (shift_en) begin
      lfsr <= {lfsr[14:0], 1'b0} ^ (feedback ? poly : 16'h0000);
    end
  end

endmodule

// File: rtl/usb_crc_encoder.sv
// Serial USB CRC encoder: streams PID, then payload through the CRC, then the
// complemented remainder MSB first, one bit per valid/ready transfer.
module usb_crc_encoder
  import usb_crc_pkg::*;
#(
  parameter int PID_BITS         = 8,
  parameter int MAX_PAYLOAD_BITS = 64,
  parameter int LEN_W            = $clog2(MAX_PAYLOAD_BITS + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 pkt_ready,
  input  logic [PID_BITS+MAX_PAYLOAD_BITS-1:0] pkt_in,
  input  logic [LEN_W-1:0]                     pkt_len,
  input  logic                                 crc_mode,
  output logic                                 pkt_accept,
  output logic                                 out_bit,
  output logic                                 out_valid,
  input  logic                                 bs_ready,
  output logic                                 busy,
  output logic                                 pkt_done
);

  localparam int                PKT_W    = PID_BITS + MAX_PAYLOAD_BITS;
  localparam int                CNT_W    = LEN_W + 1;
  localparam logic [CNT_W-1:0]  PID_LAST = CNT_W'(PID_BITS - 1);
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_PAYLOAD_BITS);

  enc_state_t       state;
  logic [PKT_W-1:0] shift;
  crc_mode_t        mode_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] bit_cnt;

  logic       xfer;
  logic       crc_last;
  logic       lfsr_bit;
  logic [3:0] crc_top;
  logic [3:0] crc_idx;

  assign out_valid = (state != S_IDLE);
  assign busy      = out_valid;
  assign xfer      = out_valid && bs_ready;

  // bit_cnt counts CRC bits sent, so the remainder index walks down from n-1.
  assign crc_top  = (mode_q == CRC_16) ? 4'(CRC16_LEN - 1) : 4'(CRC5_LEN - 1);
  assign crc_idx  = crc_top - bit_cnt[3:0];
  assign crc_last = (bit_cnt == CNT_W'(crc_top));

  assign pkt_accept = (state == S_IDLE) && pkt_ready && !reset;
  assign pkt_done   = (state == S_CRC) && xfer && crc_last;

  always_comb begin
    out_bit = 1'b0;
    case (state)
      S_PID, S_PAYLOAD: out_bit = shift[0];
      S_CRC:            out_bit = lfsr_bit;
      default:          out_bit = 1'b0;
    endcase
  end

  usb_crc_lfsr u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .init     (pkt_accept),
    .shift_en ((state == S_PAYLOAD) && xfer),
    .data_bit (shift[0]),
    .mode     (mode_q),
    .index    (crc_idx),
    .rem_bit  (lfsr_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      shift   <= '0;
      mode_q  <= CRC_5;
      len_q   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pkt_accept) begin
            shift   <= pkt_in;
            mode_q  <= crc_mode_t'(crc_mode);
            len_q   <= (pkt_len > MAX_LEN) ? MAX_LEN : pkt_len;
            bit_cnt <= '0;
            state   <= S_PID;
          end
        end
        S_PID: begin
          if (xfer) begin
            shift <= shift >> 1;
            if (bit_cnt == PID_LAST) begin
              bit_cnt <= '0;
              state   <= (len_q != '0) ? S_PAYLOAD : S_CRC;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            shift <= shift >> 1;
            if ((bit_cnt + CNT_W'(1)) == {1'b0, len_q}) begin
              bit_cnt <= '0;
              state   <= S_CRC;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_CRC: begin
          if (xfer) begin
            if (crc_last) begin
              bit_cnt <= '0;
              state   <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
